// File: rtl/io_periph_bus.sv
// io_periph_bus: memory-mapped IO page with LED register, buffered 8N1 UART TX,
// sticky TX overflow flag and a free-running cycle counter.
// Ports: clk, reset (sync, active-high); io_addr/io_wdata/io_wr bus write side;
// io_rdata combinational read data; leds LED register; txd UART serial out.
module io_periph_bus #(
  parameter int LED_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          io_addr,
  input  logic [31:0]          io_wdata,
  input  logic                 io_wr,
  output logic [31:0]          io_rdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 txd
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [3:0] wa;
  logic       sel_led;
  logic       sel_dat;
  logic       sel_cntl;
  logic       sel_cyc;
  logic       unused_addr;

  assign wa          = io_addr[5:2];
  assign sel_led     = wa[0];
  assign sel_dat     = wa[1];
  assign sel_cntl    = wa[2];
  assign sel_cyc     = wa[3];
  assign unused_addr = ^{io_addr[31:6], io_addr[1:0]};

  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [31:0]          cyc_q, cyc_d;
  logic                 ovf_q, ovf_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;
  logic                 txd_q, txd_d;

  logic [PW-1:0] level;
  logic [8:0]    level9;
  logic [7:0]    level8;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop;
  logic          push;
  logic          ovf_evt;
  logic          tx_active;

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign push_req = io_wr && sel_dat;
  assign pop      = (state_q == S_IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovf_evt  = push_req && full && !pop;

  assign tx_active = (state_q != S_IDLE) || !empty;

  always_comb begin
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (io_wr && sel_cntl && io_wdata[10]) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;
  end

  always_comb begin
    leds_d = leds_q;
    if (io_wr && sel_led) leds_d = io_wdata[LED_WIDTH-1:0];
  end

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (io_wr && sel_cyc) cyc_d = io_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          sh_d    = mem_q[rptr_q[AW-1:0]];
          cnt_d   = RELOAD;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          txd_d   = sh_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            // Next bit sits at sh_q[1] before the shift lands.
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          txd_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q  <= '0;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      leds_q  <= leds_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= io_wdata[7:0];
  end

  // Level field is 8 bits wide; a 256-deep FIFO saturates it at 255.
  assign level9 = 9'(level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];

  logic [31:0] led_rd;
  logic [31:0] cntl_rd;

  assign led_rd  = 32'(leds_q);
  assign cntl_rd = {8'h00, level8, 5'h00, ovf_q, full, tx_active, 8'h00};

  assign io_rdata = (sel_led  ? led_rd  : 32'h0) |
                    (sel_cntl ? cntl_rd : 32'h0) |
                    (sel_cyc  ? cyc_q   : 32'h0);

  assign leds = leds_q;
  assign txd  = txd_q;

endmodule

// File: tb/tb_io_periph_bus.sv
// tb_io_periph_bus: vectors, directed UART sequences and random traffic
// checked against a frame-level reference model and a serial receiver.
module tb_io_periph_bus;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int LW    = 4;

  localparam logic [31:0] A_LED  = 32'h04;
  localparam logic [31:0] A_DAT  = 32'h08;
  localparam logic [31:0] A_CNTL = 32'h10;
  localparam logic [31:0] A_CYC  = 32'h20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   io_addr = '0;
  logic [31:0]   io_wdata = '0;
  logic          io_wr = 1'b0;
  logic [31:0]   io_rdata;
  logic [LW-1:0] leds;
  logic          txd;

  io_periph_bus #(
    .LED_WIDTH(LW),
    .FIFO_DEPTH(DEPTH),
    .CLK_FREQ_HZ(10000000),
    .BAUD_RATE(1000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_addr(io_addr),
    .io_wdata(io_wdata),
    .io_wr(io_wr),
    .io_rdata(io_rdata),
    .leds(leds),
    .txd(txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the start time of the frame on the
  // wire; txd is derived from the elapsed time inside that frame.
  logic [7:0]    m_q[$];
  logic [7:0]    m_cur = '0;
  bit            m_fon = 1'b0;
  longint        m_t = 0;
  longint        m_p = 0;
  bit            m_ovf = 1'b0;
  logic [LW-1:0] m_leds = '0;
  logic [31:0]   m_cyc = '0;
  logic          m_txd = 1'b1;

  initial forever begin
    @(posedge clk);
    m_t++;
    if (reset) begin
      m_q.delete();
      m_fon  = 1'b0;
      m_ovf  = 1'b0;
      m_leds = '0;
      m_cyc  = '0;
    end else begin
      logic [3:0] w;
      int  sz;
      bit  popped;
      bit  evt;
      w = io_addr[5:2];
      sz = m_q.size();
      popped = 1'b0;
      evt = 1'b0;
      if (m_fon && (m_t - m_p == 10 * DIV)) begin
        m_fon = 1'b0;
      end else if (!m_fon && sz > 0) begin
        m_cur = m_q.pop_front();
        m_p = m_t;
        m_fon = 1'b1;
        popped = 1'b1;
      end
      if (io_wr && w[1]) begin
        if (sz < DEPTH || popped) m_q.push_back(io_wdata[7:0]);
        else evt = 1'b1;
      end
      if (io_wr && w[2] && io_wdata[10]) m_ovf = 1'b0;
      if (evt) m_ovf = 1'b1;
      if (io_wr && w[0]) m_leds = io_wdata[LW-1:0];
      if (io_wr && w[3]) m_cyc = io_wdata;
      else m_cyc = m_cyc + 32'd1;
    end
    if (!m_fon) begin
      m_txd = 1'b1;
    end else begin
      int k;
      k = int'((m_t - m_p) / DIV);
      if (k == 0) m_txd = 1'b0;
      else if (k <= 8) m_txd = m_cur[k-1];
      else m_txd = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] c;
    int sz;
    sz = m_q.size();
    c = '0;
    c[23:16] = 8'(sz);
    c[10] = m_ovf;
    c[9] = (sz == DEPTH);
    c[8] = m_fon || (sz > 0);
    r = '0;
    if (a[2]) r |= 32'(m_leds);
    if (a[4]) r |= c;
    if (a[5]) r |= m_cyc;
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("txd", {31'b0, txd}, {31'b0, m_txd});
      chk("leds", 32'(leds), 32'(m_leds));
      chk("rdata", io_rdata, exp_rd(io_addr));
    end
  end

  // Serial receiver sampling mid-bit.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = '0;
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (txd === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2 && rx_cnt / DIV >= 1 && rx_cnt / DIV <= 8)
        rx_byte[rx_cnt/DIV-1] = txd;
      if (rx_cnt == 9 * DIV + DIV / 2) begin
        rx_busy = 1'b0;
        chk("rx_stop", {31'b0, txd}, 32'd1);
        rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d);
    io_addr = a;
    io_wdata = d;
    io_wr = 1'b1;
    @(posedge clk);
    #1;
    io_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    io_addr = A_CNTL;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!io_rdata[8]) done = 1'b1;
    end
    chk("wait_idle", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    chk("rx_count", rx_q.size(), n);
  endtask

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          wr;
    logic [31:0]   raddr;
    logic [31:0]   exp_rd;
    logic [LW-1:0] exp_leds;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [9:0] frame;
    logic [31:0] addrs[10];

    vecs[0] = '{A_LED,        32'hFFFFFFF5, 1'b1, A_LED,  32'h5, 4'h5};
    vecs[1] = '{A_LED,        32'h0000000A, 1'b1, A_LED,  32'hA, 4'hA};
    vecs[2] = '{32'h40,       32'hFFFFFFFF, 1'b1, A_LED,  32'hA, 4'hA};
    vecs[3] = '{32'h40,       32'h0,        1'b0, 32'h40, 32'h0, 4'hA};
    vecs[4] = '{A_DAT,        32'h0,        1'b0, A_DAT,  32'h0, 4'hA};
    vecs[5] = '{32'h14,       32'h3,        1'b1, 32'h14, 32'h3, 4'h3};
    vecs[6] = '{32'h10004,    32'h6,        1'b1, A_LED,  32'h6, 4'h6};
    vecs[7] = '{A_CNTL,       32'hFFFFFFFF, 1'b1, A_CNTL, 32'h0, 4'h6};
    vecs[8] = '{A_LED,        32'h0,        1'b1, A_LED,  32'h0, 4'h0};

    addrs = '{A_LED, A_DAT, A_CNTL, A_CYC, 32'h14, 32'h0C,
              32'h18, 32'h3C, 32'h40, 32'h10008};

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle(50);
    io_addr = A_CYC;
    @(negedge clk);
    chk("cycles_50", io_rdata, 32'd50);
    chk("idle_txd", {31'b0, txd}, 32'd1);
    chk("idle_leds", 32'(leds), 32'd0);
    io_addr = A_CNTL;
    @(negedge clk);
    chk("idle_cntl", io_rdata, 32'h0);

    // Register vectors.
    foreach (vecs[i]) begin
      io_addr = vecs[i].addr;
      io_wdata = vecs[i].wdata;
      io_wr = vecs[i].wr;
      @(posedge clk);
      #1;
      io_wr = 1'b0;
      io_addr = vecs[i].raddr;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i), io_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end

    // Cycle counter load and wrap.
    wr_cycle(A_CYC, 32'hFFFFFFFE);
    @(negedge clk);
    chk("cyc_load", io_rdata, 32'hFFFFFFFE);
    @(negedge clk);
    chk("cyc_max", io_rdata, 32'hFFFFFFFF);
    @(negedge clk);
    chk("cyc_wrap", io_rdata, 32'h0);

    // Single frame 0x41, edge-exact.
    rx_q.delete();
    frame = {1'b1, 8'h41, 1'b0};
    wr_cycle(A_DAT, 32'h41);
    io_addr = A_CNTL;
    for (int k = 0; k <= 101; k++) begin
      logic e;
      @(negedge clk);
      if (k == 0 || k == 101) e = 1'b1;
      else e = frame[(k-1)/DIV];
      chk($sformatf("f41_txd_k%0d", k), {31'b0, txd}, {31'b0, e});
      chk($sformatf("f41_busy_k%0d", k), {31'b0, io_rdata[8]},
          (k <= 100) ? 32'd1 : 32'd0);
    end
    wait_rx(1, 50);
    if (rx_q.size() > 0) chk("rx_41", 32'(rx_q[0]), 32'h41);

    // Overflow while busy.
    rx_q.delete();
    wr_cycle(A_DAT, 32'h55);
    for (int i = 0; i < 5; i++) wr_cycle(A_DAT, 32'h30 + i);
    io_addr = A_CNTL;
    @(negedge clk);
    chk("ovf_cntl", io_rdata, 32'h00040700);
    wr_cycle(A_CNTL, 32'h400);
    @(negedge clk);
    chk("ovf_clear", io_rdata, 32'h00040300);
    wait_rx(5, 6 * 101 + 100);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("ovf_rx%0d", i), 32'(rx_q[i]),
          (i == 0) ? 32'h55 : 32'h30 + i - 1);
    repeat (200) @(negedge clk);
    chk("ovf_no_34", rx_q.size(), 5);
    wait_idle(200);

    // Push into a full FIFO on the exact pop cycle.
    rx_q.delete();
    wr_cycle(A_DAT, 32'h60);
    for (int i = 1; i <= 4; i++) wr_cycle(A_DAT, 32'h60 + i);
    idle(97);
    io_addr = A_CNTL;
    @(negedge clk);
    chk("pop_pre_cntl", io_rdata, 32'h00040300);
    wr_cycle(A_DAT, 32'h65);
    io_addr = A_CNTL;
    @(negedge clk);
    chk("pop_post_cntl", io_rdata, 32'h00040300);
    chk("pop_txd_start", {31'b0, txd}, 32'd0);
    wait_rx(6, 7 * 101 + 100);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      chk($sformatf("pop_rx%0d", i), 32'(rx_q[i]), 32'h60 + i);
    wait_idle(200);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      io_addr = addrs[$urandom_range(0, 9)];
      io_wdata = $urandom;
      io_wr = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    io_wr = 1'b0;
    wait_idle(1200);

    // Reset in the middle of data bit 3.
    wr_cycle(A_CNTL, 32'h400);
    rx_q.delete();
    wr_cycle(A_DAT, 32'hA5);
    wr_cycle(A_DAT, 32'h5A);
    idle(43);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    io_addr = A_CNTL;
    @(negedge clk);
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_cntl", io_rdata, 32'h0);
    begin
      int lows;
      lows = 0;
      repeat (300) begin
        @(negedge clk);
        if (txd !== 1'b1) lows++;
      end
      chk("rst_quiet", lows, 0);
      chk("rst_no_frame", rx_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_periph_bus.md
Name: io_periph_bus

Overview:
Parametrised memory-mapped IO page for the RV32 core's IO port. It replaces the hard-wired LED register and unbuffered UART with:
- an LED register of configurable width, readable back;
- a UART TX with a FIFO of configurable depth and an integrated 8N1 serializer;
- a sticky overflow flag;
- a free-running cycle counter.

It sits between the core's IO_memory_* signals and the board pins. Word address decoding is one-hot on addr[15:2].

Parameters:
LED_WIDTH, 4, number of LED outputs (1..32)
FIFO_DEPTH, 16, TX FIFO entries (power of two, 2..256)
CLK_FREQ_HZ, 100000000, clk frequency in Hz
BAUD_RATE, 1000000, UART bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (floor), must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
io_addr  input  32  IO byte address; only [15:2] decoded
io_wdata  input  32  write data
io_wr  input  1  write strobe, one cycle per access
io_rdata  output  32  read data, combinational from io_addr and register state
leds  output  LED_WIDTH  LED register
txd  output  1  UART serial output, idles high

Behaviour:
- Word address wa = io_addr[15:2]. Register select bits:
  - wa[0] LEDS (R/W)
  - wa[1] UART_DAT (W)
  - wa[2] UART_CNTL (R/W)
  - wa[3] CYCLES (R/W)
- If several select bits are set, a write goes to every selected register and io_rdata is the bitwise OR of the selected read values. Unselected or write-only registers read as 0.
- Reset values: leds=0, FIFO empty, overflow=0, cycles=0, txd=1, serializer IDLE, io_rdata follows state.
- Reset mid-frame: the frame is abandoned, txd=1 after the reset edge, and FIFO contents are discarded.
- LEDS: write sets leds <= io_wdata[LED_WIDTH-1:0] at the edge. Read returns zero-extended leds.
- UART_DAT: write pushes io_wdata[7:0].
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (level unchanged in that case).
  - Otherwise the byte is dropped and overflow is set (sticky).
- UART_CNTL read:
  - bit9 = FIFO full. This keeps compatibility with existing firmware that polls bit9 as "busy".
  - bit8 = tx_active (serializer not IDLE or FIFO non-empty).
  - bit10 = overflow.
  - bits[23:16] = FIFO level (0..FIFO_DEPTH, saturates in the field).
  - All other bits 0.
- UART_CNTL write: io_wdata[10]=1 clears overflow. If a same-cycle overflow event also occurs, the set wins.
- CYCLES: 32-bit counter, +1 every clk, wraps 0xFFFFFFFF -> 0. A write loads io_wdata, and the counter reads io_wdata+1 on the following cycle. Read returns the current value.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits; full/empty are derived from the pointer MSB. Level = wptr - rptr.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: txd=1. If the FIFO is non-empty, pop into an 8-bit shift register and go to START. The pop happens at the first edge after the push edge, so txd goes low 1 cycle after the push edge.
  - START: txd=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles; bit counter 0..7.
  - STOP: txd=1 for DIV cycles, then IDLE.
  - Back-to-back frames are separated by exactly one extra IDLE cycle (txd=1).
- Baud timing: a down-counter reloaded with DIV-1 at each bit start. A bit boundary occurs when the counter reaches 0. Frame length is 10*DIV cycles plus 1 IDLE cycle.
- txd is driven from a register (glitch-free).

Test Plan:
- Reset, then idle 50 cycles -> txd=1, leds=0. UART_CNTL read = 0x00000000. CYCLES read = 50 (±1 per sampling convention, checked exactly against the bench model).
- Params DIV=10. Write 0x41 to UART_DAT at edge E -> txd=0 over [E+1,E+11), then bits 1,0,0,0,0,0,1,0 each 10 cycles, stop bit high 10 cycles. bit8=1 until the frame ends.
- FIFO_DEPTH=4, five writes 0x30..0x34 in consecutive cycles, serializer busy with a prior byte -> level=4, bit9=1, bit10=1. The received stream is 0x30..0x33 and 0x34 is absent. Writing 0x400 to UART_CNTL clears bit10.
- Fill FIFO to full, then write UART_DAT in the exact cycle IDLE pops -> write accepted, level stays 4, overflow stays 0.
- LED_WIDTH=4: write 0xFFFFFFF5 to LEDS -> leds=0x5, read returns 0x00000005. Write 0xFFFFFFFE to CYCLES -> read 0xFFFFFFFF next cycle, then 0x00000000 (wrap).
- Assert reset in the middle of data bit 3 -> txd=1 after the reset edge, FIFO level=0, no further frame emitted.
